lii_rx_unpack: RTL and testbench
================================

// Module: lii_rx_unpack
// PURPOSE
//  Receive end of the LII phy link: accepts PW-bit packed LII beats, filters on dst id,
//  and serialises each beat into PW/DW narrower words on the HLS kernel input stream.
//  Sits between the LII phy output of an upstream stage and a kernel with a DW-bit input.
//  Drives the kernel clock enable and counts misaddressed beats.
// PARAMETERS
//  PW        64     LII phy packing width (bits); must be a multiple of DW
//  DW        32     kernel stream word width (bits); LANES = PW/DW (localparam, >=1)
//  LOCAL_ID  8'h00  dst id this receiver accepts
//  CHECK_DST 1      1: discard beats with dst != LOCAL_ID; 0: accept every beat
// PORTS
//  aclk               in   1    clock
//  arstn              in   1    asynchronous reset, active low
//  lii_in_p0_tdata    in   PW   packed beat, lane 0 in bits [DW-1:0]
//  lii_in_p0_tvalid   in   1    beat valid
//  lii_in_p0_tready   out  1    beat accepted when tvalid & tready
//  lii_in_p0_src      in   8    source id of beat
//  lii_in_p0_dst      in   8    destination id of beat
//  in_stream_tdata    out  DW   current lane to kernel
//  in_stream_tvalid   out  1    lane valid
//  in_stream_tready   in   1    kernel accepts lane
//  in_stream_src      out  8    src id of the beat currently being unpacked
//  drop_cnt           out  16   saturating count of discarded (misaddressed) beats
//  ce                 out  1    kernel clock enable
// BEHAVIOUR
//  - Reset (arstn=0, async): state=IDLE, hold_data=0, lane_idx=0, in_stream_src=0,
//    drop_cnt=0; so in_stream_tvalid=0, in_stream_tdata=0, lii_in_p0_tready=1, ce=0.
//    Reset mid-beat discards the remaining lanes; nothing is replayed.
//  - FSM: IDLE (holding register empty), DRAIN (holding register full, lanes pending).
//  - last_take = (state==DRAIN) & in_stream_tready & (lane_idx==LANES-1).
//  - lii_in_p0_tready = (state==IDLE) | last_take (combinational from in_stream_tready).
//  - accept = lii_in_p0_tvalid & lii_in_p0_tready; match = !CHECK_DST | (dst==LOCAL_ID).
//  - accept & match: hold_data<=tdata, in_stream_src<=src, lane_idx<=0, state<=DRAIN.
//  - accept & !match: beat discarded; drop_cnt+1, saturates at 16'hFFFF; state per below.
//  - in_stream_tvalid = (state==DRAIN); in_stream_tdata = hold_data[lane_idx*DW +: DW];
//    lanes emitted LSB lane first, one lane per handshake, no bubbles while tready=1.
//  - Lane handshake with lane_idx<LANES-1: lane_idx+1. On last_take: lane_idx wraps to 0;
//    state<=DRAIN if a matching beat is accepted in the same cycle (back-to-back, zero
//    bubble), else IDLE. Load and last_take in one cycle: new beat wins, no lane lost.
//  - Latency: beat accepted in cycle N -> lane 0 valid in cycle N+1.
//    Sustained throughput one DW lane per clock.
//  - tdata/src held stable while in_stream_tvalid & !in_stream_tready.
//  - LANES==1: every take is last_take; block behaves as a 1-deep pipeline register.
//  - ce = in_stream_tvalid & in_stream_tready (kernel advances only on a lane transfer).
//  - Upstream tvalid/tdata may change while tready=0; no beat is implied by that.
// TESTING
//  1 Reset: arstn=0 while tvalid=1 -> tready=1, in_stream_tvalid=0, drop_cnt=0, ce=0.
//  2 Single beat tdata=64'hBBBB_BBBB_AAAA_AAAA, dst=LOCAL_ID, kernel tready=1 ->
//    cycle+1 lane 32'hAAAA_AAAA, cycle+2 32'hBBBB_BBBB, then tvalid=0.
//  3 Four back-to-back matching beats, kernel tready=1 -> 8 lanes on 8 consecutive
//    cycles, no bubbles; lii_in_p0_tready high on every last lane.
//  4 Kernel tready toggled 1010... over 3 beats -> lane order/data exact, data stable
//    while stalled, ce high only on transfer cycles.
//  5 Beat dst=8'h05 with LOCAL_ID=0 -> no lanes, drop_cnt=1; with CHECK_DST=0 -> lanes
//    emitted, drop_cnt=0; force drop_cnt=16'hFFFF then drop -> stays 16'hFFFF.
//  6 arstn pulsed low after lane 0 of a beat -> lane 1 never emitted; next beat's lane 0
//    appears one cycle after its acceptance.

Source files
------------

// File: rtl/lii_rx_unpack.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lii_rx_unpack
//
// Receive end of the LII phy link. Accepts PW-bit packed beats, filters them on
// destination id, and feeds each accepted beat to the HLS kernel input stream
// as PW/DW narrower words, lowest lane first. Misaddressed beats are discarded
// and counted in a saturating 16-bit counter. The kernel clock enable pulses
// only on cycles where a lane actually transfers.
//
// Ports
//   aclk, arstn          clock, asynchronous active-low reset
//   lii_in_p0_tdata      packed beat, lane 0 in bits [DW-1:0]
//   lii_in_p0_tvalid     beat valid
//   lii_in_p0_tready     beat accepted when tvalid & tready
//   lii_in_p0_src/dst    source / destination id of the beat
//   in_stream_tdata      current lane presented to the kernel
//   in_stream_tvalid     lane valid
//   in_stream_tready     kernel accepts lane
//   in_stream_src        src id of the beat currently being unpacked
//   drop_cnt             saturating count of discarded beats
//   ce                   kernel clock enable (lane transfer)
// -----------------------------------------------------------------------------
module lii_rx_unpack #(
  parameter int unsigned PW        = 64,
  parameter int unsigned DW        = 32,
  parameter logic [7:0]  LOCAL_ID  = 8'h00,
  parameter bit          CHECK_DST = 1'b1
) (
  input  logic          aclk,
  input  logic          arstn,
  input  logic [PW-1:0] lii_in_p0_tdata,
  input  logic          lii_in_p0_tvalid,
  output logic          lii_in_p0_tready,
  input  logic [7:0]    lii_in_p0_src,
  input  logic [7:0]    lii_in_p0_dst,
  output logic [DW-1:0] in_stream_tdata,
  output logic          in_stream_tvalid,
  input  logic          in_stream_tready,
  output logic [7:0]    in_stream_src,
  output logic [15:0]   drop_cnt,
  output logic          ce
);

  localparam int unsigned    LANES    = PW / DW;
  localparam int unsigned    IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     hold_data_q, hold_data_d;
  logic [IDX_W-1:0]  lane_idx_q, lane_idx_d;
  logic [7:0]        src_q, src_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              last_take;
  logic              accept;
  logic              match;

  // Split the holding register into lane words so the output mux is a plain
  // array index rather than a variable-width part select.
  logic [DW-1:0] lane_words [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_words[g] = hold_data_q[g*DW +: DW];
  end

  assign in_stream_tvalid = (state_q == DRAIN);
  assign in_stream_tdata  = lane_words[lane_idx_q];
  assign in_stream_src    = src_q;
  assign drop_cnt         = drop_cnt_q;
  assign ce               = in_stream_tvalid & in_stream_tready;

  // Upstream ready looks through to the kernel's ready on the final lane so a
  // new beat can load in the same cycle the last lane leaves: zero bubbles.
  always_comb begin
    last_take        = (state_q == DRAIN) && in_stream_tready && (lane_idx_q == LAST_IDX);
    lii_in_p0_tready = (state_q == IDLE) || last_take;
    accept           = lii_in_p0_tvalid && lii_in_p0_tready;
    match            = (CHECK_DST == 1'b0) || (lii_in_p0_dst == LOCAL_ID);
  end

  // Next-state logic. A load in the same cycle as last_take overrides the
  // lane wrap / return to IDLE, so the new beat starts on lane 0 immediately.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    lane_idx_d  = lane_idx_q;
    src_d       = src_q;
    drop_cnt_d  = drop_cnt_q;

    if ((state_q == DRAIN) && in_stream_tready) begin
      if (last_take) begin
        lane_idx_d = '0;
        state_d    = IDLE;
      end else begin
        lane_idx_d = lane_idx_q + IDX_W'(1);
      end
    end

    if (accept) begin
      if (match) begin
        hold_data_d = lii_in_p0_tdata;
        src_d       = lii_in_p0_src;
        lane_idx_d  = '0;
        state_d     = DRAIN;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      lane_idx_q  <= '0;
      src_q       <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      lane_idx_q  <= lane_idx_d;
      src_q       <= src_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_lii_rx_unpack.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lii_rx_unpack
//
// Two instances: dut_a filters on LOCAL_ID=0, dut_b accepts every beat.
// Expected lane traffic comes from a queue model: an accepted matching beat
// appends its lane words, each kernel handshake removes the front word.
// -----------------------------------------------------------------------------
module tb_lii_rx_unpack;

  localparam int PW    = 64;
  localparam int DW    = 32;
  localparam int LANES = PW / DW;
  localparam logic [7:0] LOCAL_ID = 8'h00;

  logic aclk = 1'b0;
  logic arstn;

  always #5 aclk = ~aclk;

  logic [PW-1:0] a_tdata, b_tdata;
  logic          a_tvalid, b_tvalid;
  logic          a_tready, b_tready;
  logic [7:0]    a_src, a_dst, b_src, b_dst;
  logic [DW-1:0] a_odata, b_odata;
  logic          a_ovalid, b_ovalid;
  logic          a_kready, b_kready;
  logic [7:0]    a_osrc, b_osrc;
  logic [15:0]   a_drop, b_drop;
  logic          a_ce, b_ce;

  int errors = 0;
  int checks = 0;

  lii_rx_unpack #(.PW(PW), .DW(DW), .LOCAL_ID(LOCAL_ID), .CHECK_DST(1'b1)) dut_a (
    .aclk(aclk), .arstn(arstn),
    .lii_in_p0_tdata(a_tdata), .lii_in_p0_tvalid(a_tvalid), .lii_in_p0_tready(a_tready),
    .lii_in_p0_src(a_src), .lii_in_p0_dst(a_dst),
    .in_stream_tdata(a_odata), .in_stream_tvalid(a_ovalid), .in_stream_tready(a_kready),
    .in_stream_src(a_osrc), .drop_cnt(a_drop), .ce(a_ce)
  );

  lii_rx_unpack #(.PW(PW), .DW(DW), .LOCAL_ID(LOCAL_ID), .CHECK_DST(1'b0)) dut_b (
    .aclk(aclk), .arstn(arstn),
    .lii_in_p0_tdata(b_tdata), .lii_in_p0_tvalid(b_tvalid), .lii_in_p0_tready(b_tready),
    .lii_in_p0_src(b_src), .lii_in_p0_dst(b_dst),
    .in_stream_tdata(b_odata), .in_stream_tvalid(b_ovalid), .in_stream_tready(b_kready),
    .in_stream_src(b_osrc), .drop_cnt(b_drop), .ce(b_ce)
  );

  // Reference model of dut_a: words still owed to the kernel, their src id,
  // and the number of discarded beats.
  logic [DW-1:0] mq[$];
  logic [7:0]    m_src;
  int            m_drop;

  function automatic void m_reset();
    mq.delete();
    m_src  = 8'h00;
    m_drop = 0;
  endfunction

  // Upstream may hand over a beat when nothing is owed, or when the only word
  // owed is leaving this cycle.
  function automatic bit m_tready(input logic kready);
    return (mq.size() == 0) || ((mq.size() == 1) && (kready == 1'b1));
  endfunction

  function automatic void m_step(input logic kready, input logic tvalid,
                                 input logic [PW-1:0] data, input logic [7:0] src,
                                 input logic [7:0] dst);
    bit rdy;
    rdy = m_tready(kready);
    if ((mq.size() > 0) && kready) void'(mq.pop_front());
    if (tvalid && rdy) begin
      if (dst == LOCAL_ID) begin
        for (int i = 0; i < LANES; i++) mq.push_back(data[i*DW +: DW]);
        m_src = src;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
  endfunction

  task automatic idle_inputs();
    a_tvalid = 1'b0; a_tdata = '0; a_src = 8'h00; a_dst = LOCAL_ID; a_kready = 1'b1;
    b_tvalid = 1'b0; b_tdata = '0; b_src = 8'h00; b_dst = LOCAL_ID; b_kready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge aclk); #1;
    arstn = 1'b0;
    @(posedge aclk); #1;
    arstn = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    a_tvalid = 1'b1; a_tdata = {$urandom, $urandom}; a_dst = LOCAL_ID; a_src = 8'h5A;
    b_tvalid = 1'b1; b_tdata = {$urandom, $urandom}; b_dst = 8'h33;
    a_kready = 1'b1; b_kready = 1'b1;
    arstn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (a_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready: got %b expected 1", a_tready); end
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", a_ovalid); end
    checks++; if (a_odata !== 32'h0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", a_odata); end
    checks++; if (a_osrc !== 8'h0) begin errors++; $display("[TB] FAIL reset_src: got %h expected 0", a_osrc); end
    checks++; if (a_drop !== 16'h0) begin errors++; $display("[TB] FAIL reset_drop: got %h expected 0", a_drop); end
    checks++; if (a_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce: got %b expected 0", a_ce); end
    checks++; if (b_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_tvalid: got %b expected 0", b_ovalid); end
    idle_inputs();
    @(posedge aclk); #1;
    arstn = 1'b1;
    m_reset();
  endtask

  task automatic test_single_beat();
    do_reset();
    a_tvalid = 1'b1; a_tdata = 64'hBBBB_BBBB_AAAA_AAAA; a_dst = LOCAL_ID; a_src = 8'h3C;
    a_kready = 1'b1;
    @(negedge aclk);
    checks++; if (a_tready !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_ready: got %b expected 1", a_tready); end
    @(posedge aclk); #1;
    a_tvalid = 1'b0; a_tdata = {$urandom, $urandom};
    @(negedge aclk);
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL single_lane0_valid: got %b expected 1", a_ovalid); end
    checks++; if (a_odata !== 32'hAAAA_AAAA) begin errors++; $display("[TB] FAIL single_lane0_data: got %h expected AAAAAAAA", a_odata); end
    checks++; if (a_osrc !== 8'h3C) begin errors++; $display("[TB] FAIL single_src: got %h expected 3c", a_osrc); end
    checks++; if (a_tready !== 1'b0) begin errors++; $display("[TB] FAIL single_lane0_ready: got %b expected 0", a_tready); end
    checks++; if (a_ce !== 1'b1) begin errors++; $display("[TB] FAIL single_lane0_ce: got %b expected 1", a_ce); end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL single_lane1_valid: got %b expected 1", a_ovalid); end
    checks++; if (a_odata !== 32'hBBBB_BBBB) begin errors++; $display("[TB] FAIL single_lane1_data: got %h expected BBBBBBBB", a_odata); end
    checks++; if (a_tready !== 1'b1) begin errors++; $display("[TB] FAIL single_lane1_ready: got %b expected 1", a_tready); end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL single_done_valid: got %b expected 0", a_ovalid); end
    checks++; if (a_ce !== 1'b0) begin errors++; $display("[TB] FAIL single_done_ce: got %b expected 0", a_ce); end
  endtask

  task automatic test_back_to_back();
    int bi;
    bit exp_rdy, exp_valid;
    logic [DW-1:0] exp_data;
    int ln;
    do_reset();
    bi = 0;
    a_kready = 1'b1; a_dst = LOCAL_ID; a_src = 8'h11;
    a_tvalid = 1'b1; a_tdata = {32'hB000_0000, 32'hA000_0000};
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge aclk);
      // cycle 0 idle; odd cycles show lane 0, even cycles 2..8 show lane 1
      exp_rdy   = ((cyc % 2) == 0) || (cyc == 9);
      exp_valid = (cyc >= 1) && (cyc <= 8);
      ln        = cyc - 1;
      exp_data  = (ln % 2 == 0) ? (32'hA000_0000 + 32'(ln / 2)) : (32'hB000_0000 + 32'(ln / 2));
      checks++; if (a_ovalid !== exp_valid) begin errors++; $display("[TB] FAIL b2b_valid c%0d: got %b expected %b", cyc, a_ovalid, exp_valid); end
      checks++; if (a_tready !== exp_rdy) begin errors++; $display("[TB] FAIL b2b_ready c%0d: got %b expected %b", cyc, a_tready, exp_rdy); end
      if (exp_valid) begin
        checks++; if (a_odata !== exp_data) begin errors++; $display("[TB] FAIL b2b_data c%0d: got %h expected %h", cyc, a_odata, exp_data); end
      end
      @(posedge aclk); #1;
      if (exp_rdy && a_tvalid) bi++;
      a_tvalid = (bi < 4);
      a_tdata  = {32'hB000_0000 + 32'(bi), 32'hA000_0000 + 32'(bi)};
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [PW-1:0] beats [3];
    int bi, xfers;
    do_reset();
    for (int i = 0; i < 3; i++) beats[i] = {$urandom, $urandom};
    bi = 0; xfers = 0;
    a_dst = LOCAL_ID;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_kready = ((cyc % 2) == 0);
      a_tvalid = (bi < 3);
      if (bi < 3) a_tdata = beats[bi];
      a_src = 8'(8'h40 + bi);
      @(negedge aclk);
      checks++; if (a_ovalid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL stall_valid c%0d: got %b expected %b", cyc, a_ovalid, mq.size() > 0); end
      checks++; if (a_tready !== m_tready(a_kready)) begin errors++; $display("[TB] FAIL stall_ready c%0d: got %b expected %b", cyc, a_tready, m_tready(a_kready)); end
      checks++; if (a_ce !== ((mq.size() > 0) && a_kready)) begin errors++; $display("[TB] FAIL stall_ce c%0d: got %b expected %b", cyc, a_ce, (mq.size() > 0) && a_kready); end
      if (mq.size() > 0) begin
        checks++; if (a_odata !== mq[0]) begin errors++; $display("[TB] FAIL stall_data c%0d: got %h expected %h", cyc, a_odata, mq[0]); end
        checks++; if (a_osrc !== m_src) begin errors++; $display("[TB] FAIL stall_src c%0d: got %h expected %h", cyc, a_osrc, m_src); end
        if (a_kready) xfers++;
      end
      if (a_tvalid && m_tready(a_kready)) bi++;
      m_step(a_kready, a_tvalid, a_tdata, a_src, a_dst);
      @(posedge aclk); #1;
    end
    checks++; if (xfers != 3 * LANES) begin errors++; $display("[TB] FAIL stall_lane_count: got %0d expected %0d", xfers, 3 * LANES); end
    idle_inputs();
  endtask

  task automatic test_drop();
    do_reset();
    a_tvalid = 1'b1; a_tdata = {$urandom, $urandom}; a_dst = 8'h05; a_src = 8'h21; a_kready = 1'b1;
    b_tvalid = 1'b1; b_tdata = 64'h2222_2222_1111_1111; b_dst = 8'h05; b_src = 8'h77; b_kready = 1'b1;
    @(posedge aclk); #1;
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_lane: got %b expected 0", a_ovalid); end
    checks++; if (a_drop !== 16'd1) begin errors++; $display("[TB] FAIL drop_count1: got %0d expected 1", a_drop); end
    checks++; if (b_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL nochk_valid: got %b expected 1", b_ovalid); end
    checks++; if (b_odata !== 32'h1111_1111) begin errors++; $display("[TB] FAIL nochk_lane0: got %h expected 11111111", b_odata); end
    checks++; if (b_osrc !== 8'h77) begin errors++; $display("[TB] FAIL nochk_src: got %h expected 77", b_osrc); end
    checks++; if (b_drop !== 16'd0) begin errors++; $display("[TB] FAIL nochk_drop: got %0d expected 0", b_drop); end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++; if (b_odata !== 32'h2222_2222) begin errors++; $display("[TB] FAIL nochk_lane1: got %h expected 22222222", b_odata); end
    @(posedge aclk); #1;
    // Continuous misaddressed traffic: every clock edge is one more drop.
    a_tvalid = 1'b1;
    repeat (65533) @(posedge aclk);
    @(negedge aclk);
    checks++; if (a_drop !== 16'hFFFE) begin errors++; $display("[TB] FAIL drop_fffe: got %h expected fffe", a_drop); end
    @(posedge aclk);
    @(negedge aclk);
    checks++; if (a_drop !== 16'hFFFF) begin errors++; $display("[TB] FAIL drop_ffff: got %h expected ffff", a_drop); end
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if (a_drop !== 16'hFFFF) begin errors++; $display("[TB] FAIL drop_saturate: got %h expected ffff", a_drop); end
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_sat_valid: got %b expected 0", a_ovalid); end
    @(posedge aclk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_beat();
    do_reset();
    a_kready = 1'b1; a_dst = LOCAL_ID; a_src = 8'h01;
    a_tvalid = 1'b1; a_tdata = 64'hB111_B111_A111_A111;
    @(posedge aclk); #1;
    a_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (a_odata !== 32'hA111_A111) begin errors++; $display("[TB] FAIL rmid_lane0: got %h expected a111a111", a_odata); end
    @(posedge aclk); #1;
    arstn = 1'b0;
    @(negedge aclk);
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flushed: got %b expected 0", a_ovalid); end
    checks++; if (a_tready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready: got %b expected 1", a_tready); end
    #1 arstn = 1'b1;
    @(posedge aclk); #1;
    a_tvalid = 1'b1; a_tdata = 64'hB222_B222_A222_A222; a_src = 8'h02;
    @(negedge aclk);
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_no_replay: got %b expected 0", a_ovalid); end
    @(posedge aclk); #1;
    a_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if ((a_ovalid !== 1'b1) || (a_odata !== 32'hA222_A222)) begin errors++; $display("[TB] FAIL rmid_next_lane0: got %b/%h expected 1/a222a222", a_ovalid, a_odata); end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++; if (a_odata !== 32'hB222_B222) begin errors++; $display("[TB] FAIL rmid_next_lane1: got %h expected b222b222", a_odata); end
    @(posedge aclk); #1;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_tvalid = ($urandom_range(0, 3) != 0);
      a_tdata  = {$urandom, $urandom};
      a_src    = 8'($urandom);
      a_dst    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : LOCAL_ID;
      a_kready = ($urandom_range(0, 2) != 0);
      @(negedge aclk);
      checks++; if (a_ovalid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %b expected %b", cyc, a_ovalid, mq.size() > 0); end
      checks++; if (a_tready !== m_tready(a_kready)) begin errors++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", cyc, a_tready, m_tready(a_kready)); end
      checks++; if (a_ce !== ((mq.size() > 0) && a_kready)) begin errors++; $display("[TB] FAIL rnd_ce c%0d: got %b expected %b", cyc, a_ce, (mq.size() > 0) && a_kready); end
      if (mq.size() > 0) begin
        checks++; if (a_odata !== mq[0]) begin errors++; $display("[TB] FAIL rnd_data c%0d: got %h expected %h", cyc, a_odata, mq[0]); end
        checks++; if (a_osrc !== m_src) begin errors++; $display("[TB] FAIL rnd_src c%0d: got %h expected %h", cyc, a_osrc, m_src); end
      end
      checks++; if (a_drop !== 16'(m_drop)) begin errors++; $display("[TB] FAIL rnd_drop c%0d: got %0d expected %0d", cyc, a_drop, m_drop); end
      m_step(a_kready, a_tvalid, a_tdata, a_src, a_dst);
      @(posedge aclk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    arstn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_stall();
    test_reset_mid_beat();
    test_random();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
